axi_cfg_sequencer: RTL and testbench

//  AXI4 single-beat master that runs a queue of configuration commands against the CGRA slave port and DRAM window.

---
 rtl/axi_cfg_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_axi_cfg_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cfg_sequencer.sv
// AXI4 single-beat configuration master: queues WRITE/READ/POLL commands and
// replays them one at a time against the fabric, with sticky error handling.
module axi_cfg_sequencer #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned AXI_ID     = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned POLL_LIMIT = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // command queue
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]     cmd_data_i,
    input  logic [DATA_WIDTH-1:0]     cmd_mask_i,
    // AXI AW
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [ADDR_WIDTH-1:0]     aw_addr_o,
    output logic [ID_WIDTH-1:0]       aw_id_o,
    output logic [2:0]                aw_size_o,
    // AXI W
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    output logic [DATA_WIDTH-1:0]     w_data_o,
    output logic [DATA_WIDTH/8-1:0]   w_strb_o,
    output logic                      w_last_o,
    // AXI B
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    input  logic [1:0]                b_resp_i,
    // AXI AR
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    output logic [ADDR_WIDTH-1:0]     ar_addr_o,
    output logic [ID_WIDTH-1:0]       ar_id_o,
    output logic [2:0]                ar_size_o,
    // AXI R
    input  logic                      r_valid_i,
    output logic                      r_ready_o,
    input  logic [DATA_WIDTH-1:0]     r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    // status
    output logic [DATA_WIDTH-1:0]     rd_data_o,
    output logic                      done_o,
    output logic                      busy_o,
    output logic                      err_o,
    input  logic                      err_clr_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W1     = PTR_WIDTH + 1;
    localparam int unsigned CNT_WIDTH  = $clog2(POLL_LIMIT + 1);

    localparam logic [1:0] OP_WRITE  = 2'd0;
    localparam logic [1:0] OP_READ   = 2'd1;
    localparam logic [1:0] OP_POLL   = 2'd2;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam logic [CNT_WIDTH-1:0] LAST_ATTEMPT = CNT_WIDTH'(POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R,
        ST_ERR
    } state_e;

    // command queue storage; pointers carry a wrap bit for full/empty
    logic [1:0]            fifo_op   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_mask [FIFO_DEPTH];

    logic [PTR_W1-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_WIDTH-1:0]  wr_idx, rd_idx;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop_c, flush;

    state_e                state_q, state_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q, r_ready_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic                  poll_q, poll_d;
    logic [CNT_WIDTH-1:0]  attempt_q, attempt_d;
    logic                  done_c;
    logic                  poll_hit_c;
    logic                  unused_r_last;

    assign wr_idx     = wr_ptr_q[PTR_WIDTH-1:0];
    assign rd_idx     = rd_ptr_q[PTR_WIDTH-1:0];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]) && (wr_idx == rd_idx);
    assign flush      = (state_q == ST_ERR);

    assign cmd_ready_o = !rst_i && !fifo_full && !err_q;
    assign push        = cmd_valid_i && cmd_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PTR_W1'(1);
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W1'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_op[wr_idx]   <= cmd_op_i;
            fifo_addr[wr_idx] <= cmd_addr_i;
            fifo_data[wr_idx] <= cmd_data_i;
            fifo_mask[wr_idx] <= cmd_mask_i;
        end
    end

    assign poll_hit_c = ((r_data_i & mask_q) == (data_q & mask_q));

    // next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        poll_d     = poll_q;
        attempt_d  = attempt_q;
        pop_c      = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    addr_d    = fifo_addr[rd_idx];
                    data_d    = fifo_data[rd_idx];
                    mask_d    = fifo_mask[rd_idx];
                    poll_d    = (fifo_op[rd_idx] == OP_POLL);
                    attempt_d = '0;
                    case (fifo_op[rd_idx])
                        OP_WRITE: begin
                            state_d    = ST_WR;
                            aw_valid_d = 1'b1;
                            w_valid_d  = 1'b1;
                        end
                        OP_READ, OP_POLL: begin
                            state_d    = ST_RD_AR;
                            ar_valid_d = 1'b1;
                        end
                        default: begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            ST_WR: begin
                if (aw_ready_i) aw_valid_d = 1'b0;
                if (w_ready_i)  w_valid_d  = 1'b0;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = ST_WR_B;
                    b_ready_d = 1'b1;
                end
            end
            ST_WR_B: begin
                if (b_valid_i) begin
                    b_ready_d = 1'b0;
                    if (b_resp_i == RESP_OKAY) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end
                end
            end
            ST_RD_AR: begin
                if (ar_ready_i) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD_R;
                end
            end
            ST_RD_R: begin
                if (r_valid_i) begin
                    r_ready_d = 1'b0;
                    rd_data_d = r_data_i;
                    if (r_resp_i != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else if (!poll_q || poll_hit_c) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (attempt_q == LAST_ATTEMPT) begin
                        err_d   = 1'b1;
                        state_d = ST_ERR;
                    end else begin
                        attempt_d  = attempt_q + CNT_WIDTH'(1);
                        ar_valid_d = 1'b1;
                        state_d    = ST_RD_AR;
                    end
                end
            end
            ST_ERR: begin
                if (err_clr_i) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            poll_q     <= 1'b0;
            attempt_q  <= '0;
        end else begin
            state_q    <= state_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            poll_q     <= poll_d;
            attempt_q  <= attempt_d;
        end
    end

    // single-beat, full-width transfers only
    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = ID_WIDTH'(AXI_ID);
    assign aw_size_o  = 3'($clog2(STRB_WIDTH));
    assign w_valid_o  = w_valid_q;
    assign w_data_o   = data_q;
    assign w_strb_o   = '1;
    assign w_last_o   = 1'b1;
    assign b_ready_o  = b_ready_q;
    assign ar_valid_o = ar_valid_q;
    assign ar_addr_o  = addr_q;
    assign ar_id_o    = ID_WIDTH'(AXI_ID);
    assign ar_size_o  = 3'($clog2(STRB_WIDTH));
    assign r_ready_o  = r_ready_q;

    assign rd_data_o  = rd_data_q;
    assign done_o     = done_c;
    assign busy_o     = !fifo_empty || (state_q != ST_IDLE);
    assign err_o      = err_q;

    assign unused_r_last = r_last_i;

endmodule

// File: tb/tb_axi_cfg_sequencer.sv
// Directed bench for axi_cfg_sequencer with a latency-configurable AXI slave model.
module tb_axi_cfg_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [63:0] cmd_addr_i, cmd_data_i, cmd_mask_i;
    logic        aw_valid_o, aw_ready_i;
    logic [63:0] aw_addr_o;
    logic [3:0]  aw_id_o;
    logic [2:0]  aw_size_o;
    logic        w_valid_o, w_ready_i;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        w_last_o;
    logic        b_valid_i, b_ready_o;
    logic [1:0]  b_resp_i;
    logic        ar_valid_o, ar_ready_i;
    logic [63:0] ar_addr_o;
    logic [3:0]  ar_id_o;
    logic [2:0]  ar_size_o;
    logic        r_valid_i, r_ready_o;
    logic [63:0] r_data_i;
    logic [1:0]  r_resp_i;
    logic        r_last_i;
    logic [63:0] rd_data_o;
    logic        done_o, busy_o, err_o, err_clr_i;

    always #5 clk_i = ~clk_i;

    axi_cfg_sequencer #(
        .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .AXI_ID(0),
        .FIFO_DEPTH(4), .POLL_LIMIT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_mask_i(cmd_mask_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_id_o(aw_id_o), .aw_size_o(aw_size_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_id_o(ar_id_o), .ar_size_o(ar_size_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i),
        .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .rd_data_o(rd_data_o), .done_o(done_o), .busy_o(busy_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    // slave knobs and observation counters
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 2, r_lat = 0;
    logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
    logic [63:0] rq[$];
    int          n_aw = 0, n_w = 0, n_ar = 0, n_b = 0, n_done = 0;
    int          aw_vcyc = 0, w_vcyc = 0, prot = 0;
    logic [63:0] addr_log[$];
    logic [63:0] last_wdata = '0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // slave drives at negedge+1, monitor samples at negedge+2 (before the next posedge)
    initial begin : slave
        int aw_c, w_c, ar_c, b_c, r_c;
        logic paw_v, paw_r, pw_v, pw_r, par_v, par_r;
        logic [63:0] paw_a, pw_d, par_a;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        paw_v = 0; paw_r = 0; pw_v = 0; pw_r = 0; par_v = 0; par_r = 0;
        paw_a = '0; pw_d = '0; par_a = '0;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_valid_i = 0; b_resp_i = 0; r_valid_i = 0; r_data_i = '0; r_resp_i = 0; r_last_i = 0;
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i) begin
                aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
                paw_v = 0; pw_v = 0; par_v = 0;
            end else begin
                if (aw_ready_i) begin aw_ready_i = 0; aw_c = 0; end
                else if (aw_valid_o) begin if (aw_c >= aw_lat) aw_ready_i = 1; else aw_c++; end
                if (w_ready_i) begin w_ready_i = 0; w_c = 0; end
                else if (w_valid_o) begin if (w_c >= w_lat) w_ready_i = 1; else w_c++; end
                if (ar_ready_i) begin ar_ready_i = 0; ar_c = 0; end
                else if (ar_valid_o) begin if (ar_c >= ar_lat) ar_ready_i = 1; else ar_c++; end
                if (b_valid_i) begin b_valid_i = 0; b_c = 0; end
                else if (b_ready_o) begin
                    if (b_c >= b_lat) begin b_valid_i = 1; b_resp_i = b_resp_cfg; end
                    else b_c++;
                end
                if (r_valid_i) begin r_valid_i = 0; r_c = 0; end
                else if (r_ready_o) begin
                    if (r_c >= r_lat) begin
                        r_valid_i = 1; r_resp_i = r_resp_cfg; r_last_i = 1;
                        r_data_i = (rq.size() > 0) ? rq.pop_front() : 64'h0;
                    end else r_c++;
                end
                #1;
                if (aw_valid_o && aw_ready_i) begin n_aw++; addr_log.push_back(aw_addr_o); end
                if (w_valid_o && w_ready_i) begin n_w++; last_wdata = w_data_o; end
                if (ar_valid_o && ar_ready_i) begin n_ar++; addr_log.push_back(ar_addr_o); end
                if (b_valid_i && b_ready_o) n_b++;
                if (done_o) n_done++;
                if (aw_valid_o) aw_vcyc++;
                if (w_valid_o) w_vcyc++;
                if (paw_v && !paw_r && (!aw_valid_o || aw_addr_o != paw_a)) prot++;
                if (pw_v && !pw_r && (!w_valid_o || w_data_o != pw_d)) prot++;
                if (par_v && !par_r && (!ar_valid_o || ar_addr_o != par_a)) prot++;
                paw_v = aw_valid_o; paw_r = aw_ready_i; paw_a = aw_addr_o;
                pw_v = w_valid_o; pw_r = w_ready_i; pw_d = w_data_o;
                par_v = ar_valid_o; par_r = ar_ready_i; par_a = ar_addr_o;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic push(input logic [1:0] op, input logic [63:0] a, input logic [63:0] d,
                        input logic [63:0] m);
        int n = 0;
        cmd_valid_i = 1; cmd_op_i = op; cmd_addr_i = a; cmd_data_i = d; cmd_mask_i = m;
        while (!cmd_ready_o && n < 200) begin tick(1); n++; end
        if (n >= 200) chk("push_timeout", 64'(cmd_ready_o), 64'h1);
        tick(1);
        cmd_valid_i = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 1000) begin tick(1); n++; end
        chk("idle_timeout", 64'(busy_o), 64'h0);
    endtask

    task automatic wait_err();
        int n = 0;
        while (!err_o && n < 1000) begin tick(1); n++; end
        chk("err_timeout", 64'(err_o), 64'h1);
    endtask

    task automatic clear_err();
        err_clr_i = 1;
        tick(1);
        err_clr_i = 0;
        tick(1);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int aw0, w0, ar0, b0, d0, l0, awc0, wc0, n;
        rst_i = 1; cmd_valid_i = 0; cmd_op_i = 0; cmd_addr_i = '0; cmd_data_i = '0;
        cmd_mask_i = '0; err_clr_i = 0;
        tick(3);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'h0);
        chk("rst_valids", 64'({aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o}), 64'h0);
        chk("rst_status", 64'({done_o, busy_o, err_o}), 64'h0);
        chk("rst_rd_data", rd_data_o, 64'h0);
        rst_i = 0;
        tick(1);
        chk("idle_cmd_ready", 64'(cmd_ready_o), 64'h1);
        chk("const_fields", 64'({aw_size_o, ar_size_o, w_strb_o, w_last_o, aw_id_o, ar_id_o}),
            64'({3'd3, 3'd3, 8'hff, 1'b1, 4'd0, 4'd0}));

        // 1: single write, B after 2 cycles
        aw0 = n_aw; w0 = n_w; b0 = n_b; d0 = n_done; l0 = addr_log.size();
        push(2'd0, 64'h5000_0050, 64'h1, 64'h0);
        wait_idle();
        chk("t1_aw", 64'(n_aw - aw0), 64'd1);
        chk("t1_w", 64'(n_w - w0), 64'd1);
        chk("t1_b", 64'(n_b - b0), 64'd1);
        chk("t1_done", 64'(n_done - d0), 64'd1);
        chk("t1_addr", addr_log[l0], 64'h5000_0050);
        chk("t1_wdata", last_wdata, 64'h1);

        // 2: AW ready delayed 3 cycles, W immediate
        aw_lat = 3;
        awc0 = aw_vcyc; wc0 = w_vcyc; b0 = n_b; d0 = n_done;
        push(2'd0, 64'h5000_0058, 64'h2, 64'h0);
        wait_idle();
        chk("t2_aw_cycles", 64'(aw_vcyc - awc0), 64'd4);
        chk("t2_w_cycles", 64'(w_vcyc - wc0), 64'd1);
        chk("t2_b", 64'(n_b - b0), 64'd1);
        chk("t2_done", 64'(n_done - d0), 64'd1);
        aw_lat = 0;

        // 3: first command stalls on B while four more fill the queue
        b_lat = 8;
        rq.push_back(64'h11); rq.push_back(64'h22);
        d0 = n_done; l0 = addr_log.size();
        push(2'd0, 64'h100, 64'hA, 64'h0);
        push(2'd1, 64'h200, 64'h0, 64'h0);
        push(2'd0, 64'h300, 64'hB, 64'h0);
        push(2'd1, 64'h400, 64'h0, 64'h0);
        push(2'd0, 64'h500, 64'hC, 64'h0);
        chk("t3_full_ready", 64'(cmd_ready_o), 64'h0);
        wait_idle();
        chk("t3_done", 64'(n_done - d0), 64'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("t3_order%0d", i), addr_log[l0 + i], 64'(i + 1) << 8);
        chk("t3_rd_data", rd_data_o, 64'h22);
        chk("t3_last_wdata", last_wdata, 64'hC);
        b_lat = 1;

        // 4: poll matches on third read
        rq.push_back(64'h0); rq.push_back(64'h0); rq.push_back(64'h1);
        ar0 = n_ar; d0 = n_done;
        push(2'd2, 64'h600, 64'h1, 64'h1);
        wait_idle();
        chk("t4_ar", 64'(n_ar - ar0), 64'd3);
        chk("t4_rd_data", rd_data_o, 64'h1);
        chk("t4_done", 64'(n_done - d0), 64'd1);
        chk("t4_err", 64'(err_o), 64'h0);

        // 5: poll never matches -> timeout after 8 attempts, queue flushed
        ar0 = n_ar; aw0 = n_aw; d0 = n_done;
        push(2'd2, 64'h700, 64'h1, 64'h1);
        push(2'd0, 64'h800, 64'h3, 64'h0);
        push(2'd0, 64'h900, 64'h4, 64'h0);
        wait_err();
        tick(4);
        chk("t5_ar", 64'(n_ar - ar0), 64'd8);
        chk("t5_aw", 64'(n_aw - aw0), 64'd0);
        chk("t5_done", 64'(n_done - d0), 64'd0);
        chk("t5_ready_in_err", 64'(cmd_ready_o), 64'h0);
        cmd_valid_i = 1; cmd_op_i = 2'd0; cmd_addr_i = 64'hD00;
        err_clr_i = 1;
        tick(1);
        cmd_valid_i = 0; err_clr_i = 0;
        tick(3);
        chk("t5_err_cleared", 64'(err_o), 64'h0);
        chk("t5_flushed", 64'(busy_o), 64'h0);
        chk("t5_no_write", 64'(n_aw - aw0), 64'd0);
        chk("t5_ready_after", 64'(cmd_ready_o), 64'h1);

        // 6a: write with SLVERR
        b_resp_cfg = 2'b10;
        b0 = n_b; d0 = n_done;
        push(2'd0, 64'hA00, 64'h5, 64'h0);
        wait_err();
        chk("t6_slverr_b", 64'(n_b - b0), 64'd1);
        chk("t6_slverr_done", 64'(n_done - d0), 64'd0);
        clear_err();
        chk("t6_clr1", 64'(err_o), 64'h0);
        b_resp_cfg = 2'b00;

        // 6b: reserved op
        aw0 = n_aw; ar0 = n_ar; d0 = n_done;
        push(2'd3, 64'hB00, 64'h0, 64'h0);
        wait_err();
        tick(3);
        chk("t6_op3_axi", 64'((n_aw - aw0) + (n_ar - ar0)), 64'd0);
        chk("t6_op3_done", 64'(n_done - d0), 64'd0);
        clear_err();

        // 6c: reset while waiting in RD_R
        rq.push_back(64'hCAFE);
        push(2'd1, 64'hC00, 64'h0, 64'h0);
        wait_idle();
        chk("t6_read_data", rd_data_o, 64'hCAFE);
        r_lat = 40;
        push(2'd1, 64'hC08, 64'h0, 64'h0);
        n = 0;
        while (!r_ready_o && n < 100) begin tick(1); n++; end
        chk("t6_in_rd_r", 64'(r_ready_o), 64'h1);
        rst_i = 1;
        tick(2);
        chk("t6_rst_valids", 64'({aw_valid_o, w_valid_o, ar_valid_o, b_ready_o, r_ready_o}), 64'h0);
        chk("t6_rst_status", 64'({cmd_ready_o, done_o, busy_o, err_o}), 64'h0);
        chk("t6_rst_rd_data", rd_data_o, 64'h0);
        rst_i = 0;
        r_lat = 0;
        tick(1);
        chk("t6_post_rst_ready", 64'(cmd_ready_o), 64'h1);
        chk("axi_stable", 64'(prot), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
